mips_pipe_stage: RTL and testbench

- Parametrised elastic pipeline register for the 5-stage MIPS32 datapath. One instance replaces a fixed stage flip-flop bank (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshaking, a 2-entry skid buffer, flush with bubble insertion, and a stall-cycle counter.
- The control field is forced to a NOP pattern whenever the stage holds no valid entry, so RegWrite/MemToWrite cannot fire on bubbles.

---
 rtl/mips_pipe_stage.sv | 129 ++++++++++++
 tb/tb_mips_pipe_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_stage.sv
// Elastic pipeline register for the MIPS32 datapath: valid/ready handshake,
// optional 2-entry skid buffer, flush with bubble insertion, stall counter.
//
//   state | meaning
//   EMPTY | no entry held; out_ctrl forced to NOP_CTRL
//   ONE   | head entry valid on out_*
//   TWO   | head valid plus one entry parked in the skid slot
module mips_pipe_stage #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 9,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stateT;

  stateT             state, nextState;
  logic [DATA_W-1:0] headData, skidData;
  logic [CTRL_W-1:0] headCtrl, skidCtrl;
  logic [CNT_W-1:0]  stallCnt;
  logic              readyReg;
  logic              accept, pop;
  logic              loadHeadIn, loadHeadSkid, loadSkid;

  assign out_valid = (state != EMPTY);
  assign out_data  = headData;
  assign out_ctrl  = out_valid ? headCtrl : NOP_CTRL;
  assign occupancy = state;
  assign stall_cnt = stallCnt;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // readyReg is low during reset, so in_ready only rises after release
  generate
    if (SKID != 0) begin : gSkid
      assign in_ready = readyReg & ~flush;
    end else begin : gSingle
      assign in_ready = readyReg & (~out_valid | out_ready) & ~flush;
    end
  endgenerate

  always_comb begin
    nextState    = state;
    loadHeadIn   = 1'b0;
    loadHeadSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          nextState  = ONE;
          loadHeadIn = 1'b1;
        end
        ONE: begin
          if (accept && !pop) begin
            nextState = TWO;
            loadSkid  = 1'b1;
          end else if (accept && pop) begin
            loadHeadIn = 1'b1;
          end else if (pop) begin
            nextState = EMPTY;
          end
        end
        TWO: if (pop) begin
          nextState    = ONE;
          loadHeadSkid = 1'b1;
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      readyReg <= 1'b0;
    end else begin
      state    <= nextState;
      readyReg <= (nextState != TWO);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headData <= '0;
      headCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
    end else begin
      if (loadHeadIn) begin
        headData <= in_data;
        headCtrl <= in_ctrl;
      end else if (loadHeadSkid) begin
        headData <= skidData;
        headCtrl <= skidCtrl;
      end
      if (loadSkid) begin
        skidData <= in_data;
        skidCtrl <= in_ctrl;
      end
    end
  end

  // Saturating back-pressure counter; flush deliberately leaves it alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (out_valid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Bench for mips_pipe_stage: a skid instance driven by directed scenarios and
// random traffic, a single-entry instance driven randomly, both checked against queue models.
module tb_mips_pipe_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // SKID=1 instance signals
  logic        fl1 = 0, iv1 = 0, or1 = 0;
  logic [31:0] id1 = '0;
  logic [8:0]  ic1 = '0;
  logic        ir1, ov1;
  logic [31:0] od1;
  logic [8:0]  oc1;
  logic [1:0]  occ1;
  logic [15:0] sc1;

  // SKID=0 instance signals
  logic        fl0 = 0, iv0 = 0, or0 = 0;
  logic [31:0] id0 = '0;
  logic [8:0]  ic0 = '0;
  logic        ir0, ov0;
  logic [31:0] od0;
  logic [8:0]  oc0;
  logic [1:0]  occ0;
  logic [15:0] sc0;

  always #5 clk = ~clk;

  mips_pipe_stage #(.DATA_W(32), .CTRL_W(9), .NOP_CTRL(9'h000), .SKID(1), .CNT_W(16)) dutSkid (
    .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .in_ctrl(ic1), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1), .stall_cnt(sc1));

  mips_pipe_stage #(.DATA_W(32), .CTRL_W(9), .NOP_CTRL(9'h000), .SKID(0), .CNT_W(16)) dutSingle (
    .clk(clk), .reset(reset), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .in_ctrl(ic0), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0), .stall_cnt(sc0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural models: a FIFO of {ctrl,data}, the last head seen, and a stall count
  logic [40:0] q1[$];
  logic [40:0] q0[$];
  logic [40:0] head1 = '0, head0 = '0;
  logic [15:0] cnt1 = '0, cnt0 = '0;
  logic        room1 = 1'b0;  // skid stage: not full after the previous edge
  logic        alive0 = 1'b0; // single stage: at least one edge since reset
  logic        acc1, pop1, acc0, pop0;

  function automatic logic mReady1();
    return room1 & ~fl1;
  endfunction

  function automatic logic mReady0();
    return alive0 & ((q0.size() == 0) | or0) & ~fl0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1.delete(); head1 = '0; cnt1 = '0; room1 = 1'b0;
    end else begin
      acc1 = iv1 & mReady1();
      pop1 = (q1.size() > 0) & or1;
      if ((q1.size() > 0) && !or1 && (cnt1 != 16'hFFFF)) cnt1++;
      if (fl1) q1.delete();
      else begin
        if (pop1) void'(q1.pop_front());
        if (acc1) q1.push_back({ic1, id1});
      end
      if (q1.size() > 0) head1 = q1[0];
      room1 = (q1.size() != 2);
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete(); head0 = '0; cnt0 = '0; alive0 = 1'b0;
    end else begin
      acc0 = iv0 & mReady0();
      pop0 = (q0.size() > 0) & or0;
      if ((q0.size() > 0) && !or0 && (cnt0 != 16'hFFFF)) cnt0++;
      if (fl0) q0.delete();
      else begin
        if (pop0) void'(q0.pop_front());
        if (acc0) q0.push_back({ic0, id0});
      end
      if (q0.size() > 0) head0 = q0[0];
      alive0 = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("skid.in_ready",  ir1,  mReady1());
    chk("skid.out_valid", ov1,  q1.size() > 0);
    chk("skid.out_data",  od1,  head1[31:0]);
    chk("skid.out_ctrl",  oc1,  (q1.size() > 0) ? head1[40:32] : 9'h000);
    chk("skid.occupancy", occ1, q1.size());
    chk("skid.stall_cnt", sc1,  cnt1);
    chk("single.in_ready",  ir0,  mReady0());
    chk("single.out_valid", ov0,  q0.size() > 0);
    chk("single.out_data",  od0,  head0[31:0]);
    chk("single.out_ctrl",  oc0,  (q0.size() > 0) ? head0[40:32] : 9'h000);
    chk("single.occupancy", occ0, q0.size());
    chk("single.stall_cnt", sc0,  cnt0);
  end

  // Single-entry instance: out_ready mostly alternating, random valid/flush/payload
  always @(posedge clk) begin
    #1;
    iv0 = ($urandom_range(0, 3) != 0);
    or0 = ($urandom_range(0, 7) == 0) ? or0 : ~or0;
    fl0 = ($urandom_range(0, 31) == 0);
    id0 = $urandom;
    ic0 = 9'($urandom_range(0, 511));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    chk("rst.out_valid", ov1, 1'b0);
    chk("rst.out_ctrl",  oc1, 9'h000);
    chk("rst.out_data",  od1, 32'h0);
    chk("rst.in_ready",  ir1, 1'b0);
    chk("rst.in_ready0", ir0, 1'b0);
    chk("rst.stall_cnt", sc1, 16'h0);

    // First entry after release, then 8 back-to-back entries
    iv1 = 1; id1 = 32'h0040_0004; ic1 = 9'h1A1; or1 = 1;
    #2 reset = 1'b1;
    step();
    chk("rel.in_ready", ir1, 1'b1);
    step();
    chk("first.out_valid", ov1, 1'b1);
    chk("first.out_data",  od1, 32'h0040_0004);
    chk("first.out_ctrl",  oc1, 9'h1A1);
    for (int i = 0; i < 8; i++) begin
      id1 = 32'h100 + 32'(i);
      step();
      chk("stream.out_data",  od1, 32'h100 + 32'(i));
      chk("stream.occupancy", occ1, 2'd1);
    end
    iv1 = 0;
    step();
    chk("stream.drained", ov1, 1'b0);

    // Skid fill and ordered drain
    or1 = 0; iv1 = 1; id1 = 32'h11; ic1 = 9'h011;
    step();
    id1 = 32'h22; ic1 = 9'h022;
    step();
    iv1 = 0;
    chk("skid.occ2",     occ1, 2'd2);
    chk("skid.ready0",   ir1,  1'b0);
    chk("skid.headHeld", od1,  32'h11);
    or1 = 1;
    step();
    chk("skid.pop2nd", od1, 32'h22);
    chk("skid.ready1", ir1, 1'b1);
    step();
    chk("skid.empty", ov1, 1'b0);

    // Flush while one entry held: in_ready must drop in the flush cycle
    or1 = 0; iv1 = 1; id1 = 32'h2A; ic1 = 9'h02A;
    step();
    fl1 = 1;
    #1 chk("flush.readyLow1", ir1, 1'b0);
    step();
    fl1 = 0; iv1 = 0;
    chk("flush1.occ", occ1, 2'd0);

    // Flush while full, coinciding with a pop
    iv1 = 1; id1 = 32'h33; ic1 = 9'h033;
    step();
    id1 = 32'h44; ic1 = 9'h044;
    step();
    id1 = 32'h55; ic1 = 9'h055; fl1 = 1; or1 = 1;
    #1 chk("flush.readyLow2", ir1, 1'b0);
    step();
    fl1 = 0; iv1 = 0;
    chk("flush2.occ",   occ1, 2'd0);
    chk("flush2.valid", ov1,  1'b0);
    chk("flush2.ctrl",  oc1,  9'h000);
    repeat (3) step();
    chk("flush2.noGhost", ov1, 1'b0);

    // Stall counter saturation, survives flush
    iv1 = 1; id1 = 32'h66; ic1 = 9'h066; or1 = 0;
    step();
    iv1 = 0;
    repeat (70000) step();
    chk("stall.sat", sc1, 16'hFFFF);
    fl1 = 1;
    step();
    fl1 = 0;
    chk("stall.afterFlush", sc1, 16'hFFFF);
    chk("stall.flushOcc",   occ1, 2'd0);

    // Asynchronous reset while full
    iv1 = 1; id1 = 32'h77; ic1 = 9'h077;
    step();
    id1 = 32'h88; ic1 = 9'h088;
    step();
    iv1 = 0;
    chk("arst.preOcc", occ1, 2'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst.valid", ov1,  1'b0);
    chk("arst.ctrl",  oc1,  9'h000);
    chk("arst.occ",   occ1, 2'd0);
    chk("arst.stall", sc1,  16'h0);
    chk("arst.ready", ir1,  1'b0);
    #2 reset = 1'b1;
    iv1 = 1; id1 = 32'h99; ic1 = 9'h0AA; or1 = 1;
    step();
    step();
    iv1 = 0;
    chk("arst.newData", od1, 32'h99);
    chk("arst.newCtrl", oc1, 9'h0AA);

    // Random traffic on the skid instance
    for (int i = 0; i < 400; i++) begin
      iv1 = ($urandom_range(0, 3) != 0);
      or1 = ($urandom_range(0, 2) != 0);
      fl1 = ($urandom_range(0, 40) == 0);
      id1 = $urandom;
      ic1 = 9'($urandom_range(0, 511));
      step();
    end
    fl1 = 0; iv1 = 0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
